cdb_arbiter: RTL and testbench

- Responder side of the per-register-file CDB request handshake used by execution units such as the load/store unit.
- Each cycle it selects at most one requesting unit and asserts that unit's ready.
- It captures the winner's ROB tag in the grant cycle, then broadcasts valid, tag and data on the CDB one cycle later.
- One instance per register file: the GPR CDB and the FPR CDB.

---
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 tb/tb_cdb_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter for one register file (GPR or FPR).
// Grants at most one requesting execution unit per cycle using a
// round-robin pointer, then broadcasts the winner's tag and result
// on the CDB one cycle after the grant.

package cdb_arbiter_pkg;
    // Width of a ROB tag, shared by every unit that talks to the CDB.
    localparam int ROB_WIDTH      = 6;
    localparam int CDB_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      valid;
        logic [ROB_WIDTH-1:0]      tag;
        logic [CDB_DATA_WIDTH-1:0] data;
    } cdb_t;
endpackage

module cdb_arbiter #(
    parameter int N_REQ      = 4,   // legal range 2..8
    parameter int ROB_WIDTH  = cdb_arbiter_pkg::ROB_WIDTH,
    parameter int DATA_WIDTH = cdb_arbiter_pkg::CDB_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_REQ-1:0]                     req_valid,
    output logic [N_REQ-1:0]                     req_ready,
    input  logic [N_REQ-1:0][ROB_WIDTH-1:0]      req_tag,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_result,
    output cdb_arbiter_pkg::cdb_t                cdb
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   N_REQ_EXT = (IDX_W + 1)'(N_REQ);

    logic [IDX_W-1:0]     prio;
    logic [IDX_W-1:0]     prio_next;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_found;

    // Scan position held one bit wider than the pointer so prio+k never
    // overflows before the modulo correction (max value 2*N_REQ-2).
    logic [IDX_W:0]       scan_sum;
    logic [IDX_W-1:0]     scan_idx;

    logic                 bcast_valid;
    logic [ROB_WIDTH-1:0] bcast_tag;
    logic [IDX_W-1:0]     bcast_src;

    // Round-robin search starting at prio; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, prio} + (IDX_W + 1)'(k);
            if (scan_sum >= N_REQ_EXT) begin
                scan_sum = scan_sum - N_REQ_EXT;
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Pointer moves to the unit just after the winner, wrapping explicitly
    // so non-power-of-two N_REQ never lands on an unused index.
    always_comb begin
        prio_next = prio;
        if (grant_found) begin
            prio_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // One-hot ready to the winner; silenced entirely while reset is held.
    always_comb begin
        req_ready = '0;
        if (reset && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Pointer and broadcast pipeline registers; a grant made in a reset
    // cycle is dropped because bcast_valid clears.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio        <= '0;
            bcast_valid <= 1'b0;
            bcast_tag   <= '0;
            bcast_src   <= '0;
        end else begin
            prio        <= prio_next;
            bcast_valid <= grant_found;
            if (grant_found) begin
                bcast_tag <= req_tag[grant_idx];
                bcast_src <= grant_idx;
            end
        end
    end

    // Broadcast: data is muxed live from the registered source because the
    // unit presents its result in the cycle after its grant.
    always_comb begin
        cdb.valid = bcast_valid;
        cdb.tag   = bcast_tag;
        cdb.data  = bcast_valid ? req_result[bcast_src] : 'x;
    end

    // Protocol sanity: ready must be one-hot-or-zero and never unrequested.
    always @(posedge clk) begin
        if (reset) begin
            assert ($onehot0(req_ready))
                else $error("cdb_arbiter: req_ready not one-hot-or-zero: %b", req_ready);
            assert ((req_ready & ~req_valid) == '0)
                else $error("cdb_arbiter: ready without valid: ready=%b valid=%b",
                            req_ready, req_valid);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference model.

module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int RW = cdb_arbiter_pkg::ROB_WIDTH;
    localparam int DW = 32;

    logic                   clk;
    logic                   reset;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][RW-1:0]   req_tag;
    logic [N-1:0][DW-1:0]   req_result;
    cdb_arbiter_pkg::cdb_t  cdb;

    int checks = 0;
    int errors = 0;

    // Reference model state: pointer plus the broadcast pending for next cycle.
    int m_prio = 0;
    bit m_bv   = 0;
    int m_btag = 0;
    int m_bsrc = 0;

    cdb_arbiter #(.N_REQ(N), .ROB_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .req_result (req_result),
        .cdb        (cdb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare DUT against the model at mid-cycle, then advance the model
    // to what the coming posedge should latch. Returns the expected winner.
    task automatic check_cycle(output int w);
        logic [N-1:0] exp_ready;
        @(negedge clk);
        w = -1;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_prio + k) % N;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        check("ready", 64'(req_ready), 64'(exp_ready));
        check("cdb_valid", 64'(cdb.valid), 64'(m_bv));
        if (m_bv) begin
            check("cdb_tag", 64'(cdb.tag), 64'(m_btag));
            check("cdb_data", 64'(cdb.data), 64'(req_result[m_bsrc]));
        end
        if (!reset) begin
            m_prio = 0;
            m_bv   = 0;
        end else if (w >= 0) begin
            m_prio = (w + 1) % N;
            m_bv   = 1;
            m_btag = int'(req_tag[w]);
            m_bsrc = w;
        end else begin
            m_bv = 0;
        end
    endtask

    initial begin
        int w;
        int last_w;
        logic [3:0] contend_seq [5];
        contend_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        clk        = 0;
        reset      = 0;
        req_valid  = '0;
        req_tag    = '0;
        req_result = '0;
        tick();

        // Reset then idle
        check_cycle(w);
        check("rst_ready", 64'(req_ready), 64'd0);
        tick();
        reset = 1;
        repeat (3) begin
            check_cycle(w);
            check("idle_cdb_valid", 64'(cdb.valid), 64'd0);
            tick();
        end

        // Single request from unit 2
        req_valid  = 4'b0100;
        req_tag[2] = 6'd5;
        check_cycle(w);
        check("single_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid     = '0;
        req_result[2] = 32'hDEADBEEF;
        check_cycle(w);
        check("single_valid", 64'(cdb.valid), 64'd1);
        check("single_tag", 64'(cdb.tag), 64'd5);
        check("single_data", 64'(cdb.data), 64'hDEADBEEF);
        tick();

        // Skip and wrap: pointer at 3, units 0 and 1 requesting
        req_valid  = 4'b0011;
        req_tag[0] = 6'd7;
        req_tag[1] = 6'd8;
        check_cycle(w);
        check("wrap_ready0", 64'(req_ready), 64'b0001);
        tick();
        check_cycle(w);
        check("wrap_ready1", 64'(req_ready), 64'b0010);
        tick();

        // Full contention straight out of reset
        req_valid = '0;
        reset     = 0;
        check_cycle(w);
        tick();
        reset     = 1;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_tag[i] = RW'(10 + i);
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) req_result[i] = $urandom;
            check_cycle(w);
            check("contend_ready", 64'(req_ready), 64'(contend_seq[c]));
            tick();
        end

        // Back-to-back grants to unit 1
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                req_valid  = 4'b0010;
                req_tag[1] = RW'(c + 1);
            end else begin
                req_valid = '0;
            end
            if (c > 0) req_result[1] = DW'(c * 10);
            check_cycle(w);
            if (c > 0) begin
                check("b2b_valid", 64'(cdb.valid), 64'd1);
                check("b2b_tag", 64'(cdb.tag), 64'(c));
                check("b2b_data", 64'(cdb.data), 64'(c * 10));
            end
            tick();
        end

        // Reset mid-operation drops the grant and rewinds the pointer
        req_valid  = 4'b0001;
        req_tag[0] = 6'd9;
        reset      = 0;
        check_cycle(w);
        check("midrst_ready", 64'(req_ready), 64'd0);
        tick();
        reset     = 1;
        req_valid = 4'b0110;
        check_cycle(w);
        check("midrst_cdb_valid", 64'(cdb.valid), 64'd0);
        check("midrst_prio0", 64'(req_ready), 64'b0010);
        tick();

        // Randomized traffic; ungranted requesters hold valid and tag
        last_w = w;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && i != last_w)) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_tag[i]   = RW'($urandom);
                end
                req_result[i] = $urandom;
            end
            reset = ($urandom_range(0, 39) != 0);
            check_cycle(last_w);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
